// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between a UART rx/tx pair and a combinational ALU.
// Collects A, B and opcode bytes, captures the ALU result and hands it to the transmitter.
module uart_alu_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int OP_WIDTH      = 6,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_ticks,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_frame_err,
    output logic                  o_overrun
);

    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        GET_B,
        GET_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   alu_a_q;
    logic [DATA_WIDTH-1:0]   alu_b_q;
    logic [OP_WIDTH-1:0]     alu_op_q;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic                    tx_start_q;
    logic                    busy_q;
    logic                    frame_err_q;
    logic                    overrun_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so each one lasts exactly one cycle;
            // all state uses <= so every register sees the pre-edge values.
            tx_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;

            case (state_q)
                IDLE: begin
                    if (i_rx_done) begin
                        alu_a_q <= i_rx_data;
                        state_q <= GET_B;
                        busy_q  <= 1'b1;
                    end
                end

                GET_B, GET_OP: begin
                    // A byte arriving on the terminal tick wins over the timeout.
                    if (i_rx_done) begin
                        if (state_q == GET_B) begin
                            alu_b_q <= i_rx_data;
                            state_q <= GET_OP;
                        end else begin
                            alu_op_q <= i_rx_data[OP_WIDTH-1:0];
                            state_q  <= EXEC;
                        end
                    end else if (i_ticks && cnt_q == CNT_LAST) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                    end else if (i_ticks) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end

                EXEC: begin
                    tx_data_q  <= i_alu_result;
                    tx_start_q <= 1'b1;
                    overrun_q  <= i_rx_done;
                    state_q    <= SEND;
                end

                SEND: begin
                    overrun_q <= i_rx_done;
                    state_q   <= WAIT_TX;
                end

                WAIT_TX: begin
                    overrun_q <= i_rx_done;
                    if (i_tx_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;
    assign o_alu_op    = alu_op_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: vector table for nominal frames plus
// hand-written timeout, collision and reset sequences.
module tb_uart_alu_ctrl;

    localparam int TO = 640;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ticks = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] alu_result;
    logic       tx_done = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    uart_alu_ctrl #(
        .DATA_WIDTH   (8),
        .OP_WIDTH     (6),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_ticks     (ticks),
        .i_rx_done   (rx_done),
        .i_rx_data   (rx_data),
        .i_alu_result(alu_result),
        .i_tx_done   (tx_done),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_busy      (busy),
        .o_frame_err (frame_err),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    // ALU model: 0x20 ADD, 0x22 SUB, anything else XOR.
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    typedef struct {
        logic       rx;
        logic [7:0] data;
        logic       tick;
        logic       txd;
        logic       busy;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic       start;
        logic [7:0] txdata;
        logic       ferr;
        logic       ovr;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_busy, input logic [7:0] e_a,
                             input logic [7:0] e_b, input logic [5:0] e_op, input logic e_start,
                             input logic [7:0] e_txd, input logic e_ferr, input logic e_ovr);
        check({tag, ".busy"},      32'(busy),      32'(e_busy));
        check({tag, ".alu_a"},     32'(alu_a),     32'(e_a));
        check({tag, ".alu_b"},     32'(alu_b),     32'(e_b));
        check({tag, ".alu_op"},    32'(alu_op),    32'(e_op));
        check({tag, ".tx_start"},  32'(tx_start),  32'(e_start));
        check({tag, ".tx_data"},   32'(tx_data),   32'(e_txd));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(e_ferr));
        check({tag, ".overrun"},   32'(overrun),   32'(e_ovr));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given inputs, then return inputs to idle.
    task automatic cyc(input logic r, input logic [7:0] d, input logic t, input logic x);
        rx_done = r;
        rx_data = d;
        ticks   = t;
        tx_done = x;
        step();
        rx_done = 1'b0;
        rx_data = 8'h00;
        ticks   = 1'b0;
        tx_done = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        //            rx  data  tk txd busy  a      b      op     st txdata ferr ovr
        vecs[0]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h05, 8'h03, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 8'h05, 8'h03, 6'h20, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h05, 8'h03, 6'h20, 1'b1, 8'h08, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h05, 8'h03, 6'h20, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h05, 8'h03, 6'h20, 1'b0, 8'h08, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h05, 8'h03, 6'h20, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 8'h0A, 8'h03, 6'h20, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h0A, 8'h04, 6'h20, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'hE2, 1'b0, 1'b0, 1'b1, 8'h0A, 8'h04, 6'h22, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h0A, 8'h04, 6'h22, 1'b1, 8'h06, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0A, 8'h04, 6'h22, 1'b0, 8'h06, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0A, 8'h04, 6'h22, 1'b0, 8'h06, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h0A, 8'h04, 6'h22, 1'b0, 8'h06, 1'b0, 1'b0};

        step();
        step();
        check_all("reset", 1'b0, 8'h00, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check_all("idle_ignore", 1'b0, 8'h00, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Nominal ADD frame, overrun in WAIT_TX, truncated SUB opcode, overrun in EXEC.
        for (int i = 0; i < 14; i++) begin
            rx_done = vecs[i].rx;
            rx_data = vecs[i].data;
            ticks   = vecs[i].tick;
            tx_done = vecs[i].txd;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].busy, vecs[i].a, vecs[i].b, vecs[i].op,
                      vecs[i].start, vecs[i].txdata, vecs[i].ferr, vecs[i].ovr);
        end
        rx_done = 1'b0;
        rx_data = 8'h00;
        ticks   = 1'b0;
        tx_done = 1'b0;

        // Timeout in GET_B, then a fresh frame.
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        check_all("to_a", 1'b1, 8'h11, 8'h04, 6'h22, 1'b0, 8'h06, 1'b0, 1'b0);
        repeat (TO - 1) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_all("to_pre", 1'b1, 8'h11, 8'h04, 6'h22, 1'b0, 8'h06, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_all("to_fire", 1'b0, 8'h11, 8'h04, 6'h22, 1'b0, 8'h06, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_all("to_after", 1'b0, 8'h11, 8'h04, 6'h22, 1'b0, 8'h06, 1'b0, 1'b0);
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        cyc(1'b1, 8'h20, 1'b0, 1'b0);
        check_all("fresh_op", 1'b1, 8'h01, 8'h02, 6'h20, 1'b0, 8'h06, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_all("fresh_send", 1'b1, 8'h01, 8'h02, 6'h20, 1'b1, 8'h03, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_all("fresh_done", 1'b0, 8'h01, 8'h02, 6'h20, 1'b0, 8'h03, 1'b0, 1'b0);

        // Byte on the terminal tick in GET_B is accepted; GET_OP then times out after a full window.
        cyc(1'b1, 8'h30, 1'b0, 1'b0);
        repeat (TO - 1) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h40, 1'b1, 1'b0);
        check_all("coll_b", 1'b1, 8'h30, 8'h40, 6'h20, 1'b0, 8'h03, 1'b0, 1'b0);
        repeat (TO - 1) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_all("coll_pre", 1'b1, 8'h30, 8'h40, 6'h20, 1'b0, 8'h03, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_all("coll_op_to", 1'b0, 8'h30, 8'h40, 6'h20, 1'b0, 8'h03, 1'b1, 1'b0);

        // Reset in GET_OP.
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        cyc(1'b1, 8'hBB, 1'b0, 1'b0);
        reset_pulse();
        check_all("rst_getop", 1'b0, 8'h00, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset in WAIT_TX, then a stale tx_done and a new frame start.
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        cyc(1'b1, 8'h20, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_all("pre_rst_wait", 1'b1, 8'h01, 8'h02, 6'h20, 1'b0, 8'h03, 1'b0, 1'b0);
        reset_pulse();
        check_all("rst_wait", 1'b0, 8'h00, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_all("stale_txdone", 1'b0, 8'h00, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h66, 1'b0, 1'b0);
        check_all("post_rst_a", 1'b1, 8'h66, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
